// File: rtl/border_fx_sequencer.sv
// border_fx_sequencer
//   Sequencer and configurator for the animated border/background stage.
//   Raw board buttons are synchronized and debounced into press events.
//   Presses become sticky requests, and those requests are committed only on
//   the rising edge of the per-frame sync. A pattern or phase change
//   therefore never lands mid-frame.
//
// Ports
//   clk            in   pixel clock
//   rst            in   synchronous reset, active-high
//   frame_start    in   frame sync (rising edge = frame boundary)
//   btn_next       in   raw button: advance pattern
//   btn_mode       in   raw button: cycle MANUAL -> AUTO -> FREEZE
//   speed_in [2:0] in   hue phase increment per frame
//   bg_sel   [1:0] out  pattern select
//   hue_phase[8:0] out  animation phase, 0..HUE_MOD-1
//   mode     [1:0] out  00 MANUAL, 01 AUTO, 10 FREEZE
//   pattern_change out  1-cycle pulse in the cycle bg_sel shows a new value
module border_fx_sequencer #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  AUTO_FRAMES     = 8'd120,
  parameter logic [8:0]  HUE_MOD         = 9'd360
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic [2:0] speed_in,
  output logic [1:0] bg_sel,
  output logic [8:0] hue_phase,
  output logic [1:0] mode,
  output logic       pattern_change
);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FREEZE = 2'b10
  } mode_t;

  // Modular phase step; the sum is formed one bit wider so 359+7 cannot alias.
  function automatic logic [8:0] hue_step(input logic [8:0] h, input logic [2:0] s);
    logic [9:0] t;
    t = {1'b0, h} + {7'd0, s};
    if (t >= {1'b0, HUE_MOD}) t = t - {1'b0, HUE_MOD};
    return t[8:0];
  endfunction

  // Bit 0 = next button, bit 1 = mode button
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d, db_prev_q;
  logic [1:0][19:0] dbc_q, dbc_d;
  logic [1:0]       press;
  logic             fs_prev_q, fs_evt;

  mode_t      mode_q, mode_d;
  logic [1:0] bg_q, bg_d;
  logic [8:0] hue_q, hue_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       next_pend_q, next_pend_d;
  logic       mode_pend_q, mode_pend_d;
  logic       pc_q, pc_d;
  logic       next_req, mode_req;

  // ---- input conditioning stage: synchronizer, debounce, edge detect ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      dbc_q     <= '0;
      fs_prev_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_mode, btn_next};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbc_q     <= dbc_d;
      fs_prev_q <= frame_start;
    end
  end

  always_comb begin
    db_d  = db_q;
    dbc_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
          db_d[i]  = ~db_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + 20'd1;
        end
      end
    end
  end

  assign press  = db_q & ~db_prev_q;
  assign fs_evt = frame_start & ~fs_prev_q;

  // ---- commit stage: mode FSM, pattern, phase ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_MANUAL;
      bg_q        <= '0;
      hue_q       <= '0;
      fcnt_q      <= '0;
      next_pend_q <= 1'b0;
      mode_pend_q <= 1'b0;
      pc_q        <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      bg_q        <= bg_d;
      hue_q       <= hue_d;
      fcnt_q      <= fcnt_d;
      next_pend_q <= next_pend_d;
      mode_pend_q <= mode_pend_d;
      pc_q        <= pc_d;
    end
  end

  // A press arriving in the commit cycle itself is folded into that commit.
  assign next_req = next_pend_q | press[0];
  assign mode_req = mode_pend_q | press[1];

  always_comb begin
    mode_d      = mode_q;
    bg_d        = bg_q;
    hue_d       = hue_q;
    fcnt_d      = fcnt_q;
    next_pend_d = next_req;
    mode_pend_d = mode_req;
    pc_d        = 1'b0;
    if (fs_evt) begin
      next_pend_d = 1'b0;
      mode_pend_d = 1'b0;
      if (mode_req) begin
        // Mode change wins; a pending next request is dropped.
        unique case (mode_q)
          MODE_MANUAL: begin
            mode_d = MODE_AUTO;
            fcnt_d = '0;
          end
          MODE_AUTO: mode_d = MODE_FREEZE;
          default:   mode_d = MODE_MANUAL;
        endcase
      end else begin
        unique case (mode_q)
          MODE_MANUAL: if (next_req) bg_d = bg_q + 2'd1;
          MODE_AUTO: begin
            if (fcnt_q + 8'd1 == AUTO_FRAMES) begin
              bg_d   = bg_q + 2'd1;
              fcnt_d = '0;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
      // Phase advance follows the mode in force during the finished frame.
      if (mode_q != MODE_FREEZE) hue_d = hue_step(hue_q, speed_in);
      pc_d = (bg_d != bg_q);
    end
  end

  assign bg_sel         = bg_q;
  assign hue_phase      = hue_q;
  assign mode           = mode_q;
  assign pattern_change = pc_q;

endmodule

// File: tb/tb_border_fx_sequencer.sv
module tb_border_fx_sequencer;
  localparam logic [19:0] DB = 20'd8;
  localparam logic [7:0]  AF = 8'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic [2:0] speed_in = 3'd0;
  logic [1:0] bg_sel;
  logic [8:0] hue_phase;
  logic [1:0] mode;
  logic       pattern_change;

  int tests_run = 0;
  int tests_failed = 0;

  border_fx_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_FRAMES(AF),
    .HUE_MOD(9'd360)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .btn_next(btn_next),
    .btn_mode(btn_mode),
    .speed_in(speed_in),
    .bg_sel(bg_sel),
    .hue_phase(hue_phase),
    .mode(mode),
    .pattern_change(pattern_change)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic do_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    tick(2);
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    tick(16);
    btn_next = 1'b0;
    tick(16);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick(16);
    btn_mode = 1'b0;
    tick(16);
  endtask

  task automatic test_reset();
    speed_in = 3'd0;
    do_reset();
    tests_run++;
    if (bg_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_bg_sel: got %0d expected 0", bg_sel); end
    tests_run++;
    if (hue_phase !== 9'd0) begin tests_failed++; $display("FAIL reset_hue: got %0d expected 0", hue_phase); end
    tests_run++;
    if (mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    tests_run++;
    if (pattern_change !== 1'b0) begin tests_failed++; $display("FAIL reset_pc: got %0b expected 0", pattern_change); end
    speed_in = 3'd3;
    repeat (10) do_frame();
    tests_run++;
    if (hue_phase !== 9'd30) begin tests_failed++; $display("FAIL hue_10_frames: got %0d expected 30", hue_phase); end
  endtask

  task automatic test_hue_wrap();
    int exp_h;
    do_reset();
    speed_in = 3'd7;
    repeat (51) do_frame();
    tests_run++;
    if (hue_phase !== 9'd357) begin tests_failed++; $display("FAIL hue_357: got %0d expected 357", hue_phase); end
    do_frame();
    tests_run++;
    if (hue_phase !== 9'd4) begin tests_failed++; $display("FAIL hue_wrap: got %0d expected 4", hue_phase); end
    exp_h = 4;
    for (int f = 0; f < 1000; f++) begin
      do_frame();
      exp_h = (exp_h + 7) % 360;
      tests_run++;
      if (hue_phase !== 9'(exp_h) || hue_phase >= 9'd360) begin
        tests_failed++;
        $display("FAIL hue_long frame %0d: got %0d expected %0d", f, hue_phase, exp_h);
      end
    end
    // bg_sel must not have moved without any button press
    tests_run++;
    if (bg_sel !== 2'd0) begin tests_failed++; $display("FAIL hue_bg_static: got %0d expected 0", bg_sel); end
  endtask

  task automatic test_debounce();
    int pcs;
    do_reset();
    speed_in = 3'd0;
    repeat (5) begin
      btn_next = 1'b1; tick(3);
      btn_next = 1'b0; tick(3);
    end
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd0) begin tests_failed++; $display("FAIL bounce_only: got %0d expected 0", bg_sel); end
    repeat (5) begin
      btn_next = 1'b1; tick(3);
      btn_next = 1'b0; tick(3);
    end
    btn_next = 1'b1;
    tick(16);
    tests_run++;
    if (bg_sel !== 2'd0 || pattern_change !== 1'b0) begin
      tests_failed++; $display("FAIL debounce_before_frame: bg %0d pc %0b expected 0 0", bg_sel, pattern_change);
    end
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    tests_run++;
    if (bg_sel !== 2'd1 || pattern_change !== 1'b1) begin
      tests_failed++; $display("FAIL debounce_commit: bg %0d pc %0b expected 1 1", bg_sel, pattern_change);
    end
    pcs = 0;
    for (int i = 0; i < 8; i++) begin
      if (pattern_change === 1'b1) pcs++;
      @(negedge clk);
    end
    tests_run++;
    if (pcs != 1) begin tests_failed++; $display("FAIL pc_width: got %0d cycles expected 1", pcs); end
    do_frame();
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd1) begin tests_failed++; $display("FAIL held_no_repeat: got %0d expected 1", bg_sel); end
    btn_next = 1'b0;
    tick(16);
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd1) begin tests_failed++; $display("FAIL release_no_event: got %0d expected 1", bg_sel); end
  endtask

  task automatic test_multi_press();
    do_reset();
    speed_in = 3'd0;
    press_next();
    press_next();
    press_next();
    tests_run++;
    if (bg_sel !== 2'd0) begin tests_failed++; $display("FAIL multi_before_frame: got %0d expected 0", bg_sel); end
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd1) begin tests_failed++; $display("FAIL multi_collapse: got %0d expected 1", bg_sel); end
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd1) begin tests_failed++; $display("FAIL multi_no_carry: got %0d expected 1", bg_sel); end
    // Align the debounced press event with the frame_start rising edge:
    // 2 sync stages + DB debounce cycles + 1 edge-detect register.
    @(negedge clk) btn_next = 1'b1;
    repeat (10) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    tests_run++;
    if (bg_sel !== 2'd2) begin tests_failed++; $display("FAIL coincident_press: got %0d expected 2", bg_sel); end
    btn_next = 1'b0;
    tick(16);
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd2) begin tests_failed++; $display("FAIL coincident_no_dup: got %0d expected 2", bg_sel); end
  endtask

  task automatic test_auto_freeze();
    int cnt;
    int exp_bg;
    do_reset();
    speed_in = 3'd0;
    press_mode();
    do_frame();
    tests_run++;
    if (mode !== 2'd1 || bg_sel !== 2'd0) begin
      tests_failed++; $display("FAIL enter_auto: mode %0d bg %0d expected 1 0", mode, bg_sel);
    end
    cnt = 0;
    exp_bg = 0;
    for (int f = 0; f < 16; f++) begin
      if (f == 5 || f == 9) press_next();
      do_frame();
      cnt++;
      if (cnt == 4) begin
        exp_bg = (exp_bg + 1) % 4;
        cnt = 0;
      end
      tests_run++;
      if (bg_sel !== 2'(exp_bg)) begin
        tests_failed++; $display("FAIL auto_frame %0d: got %0d expected %0d", f, bg_sel, exp_bg);
      end
    end
    press_mode();
    do_frame();
    tests_run++;
    if (mode !== 2'd2 || bg_sel !== 2'(exp_bg)) begin
      tests_failed++; $display("FAIL enter_freeze: mode %0d bg %0d expected 2 %0d", mode, bg_sel, exp_bg);
    end
    speed_in = 3'd5;
    for (int f = 0; f < 8; f++) begin
      if (f == 3) press_next();
      do_frame();
      tests_run++;
      if (mode !== 2'd2 || bg_sel !== 2'(exp_bg) || hue_phase !== 9'd0) begin
        tests_failed++;
        $display("FAIL freeze_frame %0d: mode %0d bg %0d hue %0d expected 2 %0d 0", f, mode, bg_sel, hue_phase, exp_bg);
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    speed_in = 3'd2;
    do_frame();
    press_next();
    press_mode();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tests_run++;
    if (bg_sel !== 2'd0 || hue_phase !== 9'd0 || mode !== 2'd0 || pattern_change !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_reset: bg %0d hue %0d mode %0d pc %0b expected 0 0 0 0", bg_sel, hue_phase, mode, pattern_change);
    end
    do_frame();
    tests_run++;
    if (bg_sel !== 2'd0 || hue_phase !== 9'd2 || mode !== 2'd0) begin
      tests_failed++;
      $display("FAIL after_reset_frame: bg %0d hue %0d mode %0d expected 0 2 0", bg_sel, hue_phase, mode);
    end
  endtask

  initial begin
    test_reset();
    test_hue_wrap();
    test_debounce();
    test_multi_press();
    test_auto_freeze();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
